// File: rtl/osd_reg_arb_pkg.sv
// Shared types for the OSD register-port arbiter: FSM state encoding,
// the registered backend command and the captured backend response.
package osd_reg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic        write;
        logic [15:0] addr;
        logic [1:0]  size;
        logic [15:0] wdata;
    } reg_cmd_t;

    typedef struct packed {
        logic        err;
        logic [15:0] rdata;
    } reg_rsp_t;

    localparam reg_cmd_t CMD_RESET = '0;
    localparam reg_rsp_t RSP_RESET = '0;

endpackage

// File: rtl/osd_rr_arbiter.sv
// Combinational round-robin picker: the search starts one slot after ptr.
// Ports: req (request vector), ptr (last winner), en (arbitrate now),
//        grant (one-hot winner, zero if none/disabled), idx (encoded winner).
module osd_rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic          found;
    logic [IW-1:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        // k = 1..N visits ptr+1 first and ptr itself last
        for (int unsigned k = 1; k <= N; k++) begin
            pos = IW'((32'(ptr) + k) % N);
            if (en && !found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/osd_reg_arbiter.sv
// Round-robin arbiter sharing one reg_request/reg_ack port among NUM_REQ
// requesters; one access in flight, response routed back to its issuer.
// Ports: req_* (per-requester access side), reg_* (shared backend side).
// Optional watchdog: define OSD_REG_ARB_TIMEOUT_EN to abort accesses that
// see no reg_ack within TIMEOUT cycles (returned with req_err=1, rdata=0).
module osd_reg_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_request,
    input  logic [NUM_REQ-1:0]       req_write,
    input  logic [NUM_REQ-1:0][15:0] req_addr,
    input  logic [NUM_REQ-1:0][1:0]  req_size,
    input  logic [NUM_REQ-1:0][15:0] req_wdata,
    output logic [NUM_REQ-1:0]       req_ack,
    output logic                     req_err,
    output logic [15:0]              req_rdata,
    output logic                     reg_request,
    output logic                     reg_write,
    output logic [15:0]              reg_addr,
    output logic [1:0]               reg_size,
    output logic [15:0]              reg_wdata,
    input  logic                     reg_ack,
    input  logic                     reg_err,
    input  logic [15:0]              reg_rdata
);

    import osd_reg_arb_pkg::*;

    localparam int unsigned IW = $clog2(NUM_REQ);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] gnt_q, gnt_d;
    reg_cmd_t      cmd_q, cmd_d;
    reg_rsp_t      rsp_q, rsp_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;

    osd_rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .req   (req_request),
        .ptr   (ptr_q),
        .en    (state_q == ST_IDLE),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

`ifdef OSD_REG_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt_q, cnt_d;
`else
    localparam int unsigned unused_timeout = TIMEOUT;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cmd_d   = cmd_q;
        rsp_d   = rsp_q;
`ifdef OSD_REG_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|arb_grant) begin
                    gnt_d       = arb_idx;
                    cmd_d.write = req_write[arb_idx];
                    cmd_d.addr  = req_addr[arb_idx];
                    cmd_d.size  = req_size[arb_idx];
                    cmd_d.wdata = req_wdata[arb_idx];
                    state_d     = ST_ISSUE;
`ifdef OSD_REG_ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            ST_ISSUE: begin
                // a real ack always beats a coincident timeout
                if (reg_ack) begin
                    rsp_d.err   = reg_err;
                    rsp_d.rdata = reg_rdata;
                    state_d     = ST_RESP;
                end
`ifdef OSD_REG_ARB_TIMEOUT_EN
                else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    rsp_d.err   = 1'b1;
                    rsp_d.rdata = '0;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                ptr_d   = gnt_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= IW'(NUM_REQ - 1);
            gnt_q   <= '0;
            cmd_q   <= CMD_RESET;
            rsp_q   <= RSP_RESET;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cmd_q   <= cmd_d;
            rsp_q   <= rsp_d;
        end
    end

`ifdef OSD_REG_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        req_ack = '0;
        if (state_q == ST_RESP) begin
            req_ack[gnt_q] = 1'b1;
        end
    end

    assign req_err     = rsp_q.err;
    assign req_rdata   = rsp_q.rdata;
    assign reg_request = (state_q == ST_ISSUE);
    assign reg_write   = cmd_q.write;
    assign reg_addr    = cmd_q.addr;
    assign reg_size    = cmd_q.size;
    assign reg_wdata   = cmd_q.wdata;

endmodule

// File: tb/tb_osd_reg_arbiter.sv
// Self-checking bench for osd_reg_arbiter (3 requesters, TIMEOUT=4).
// Watchdog sequence is included when OSD_REG_ARB_TIMEOUT_EN is defined.
module tb_osd_reg_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic [N-1:0]       req_request;
    logic [N-1:0]       req_write;
    logic [N-1:0][15:0] req_addr;
    logic [N-1:0][1:0]  req_size;
    logic [N-1:0][15:0] req_wdata;
    logic [N-1:0]       req_ack;
    logic               req_err;
    logic [15:0]        req_rdata;
    logic               reg_request;
    logic               reg_write;
    logic [15:0]        reg_addr;
    logic [1:0]         reg_size;
    logic [15:0]        reg_wdata;
    logic               reg_ack;
    logic               reg_err;
    logic [15:0]        reg_rdata;

    osd_reg_arbiter #(
        .NUM_REQ (N),
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_request (req_request),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .req_wdata   (req_wdata),
        .req_ack     (req_ack),
        .req_err     (req_err),
        .req_rdata   (req_rdata),
        .reg_request (reg_request),
        .reg_write   (reg_write),
        .reg_addr    (reg_addr),
        .reg_size    (reg_size),
        .reg_wdata   (reg_wdata),
        .reg_ack     (reg_ack),
        .reg_err     (reg_err),
        .reg_rdata   (reg_rdata)
    );

    // backend model: acks after bk_delay wait cycles, combinationally
    logic [15:0] bk_rdata = 16'h0;
    logic        bk_err   = 1'b0;
    logic        bk_never = 1'b0;
    int          bk_delay = 0;
    int          bk_wait;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bk_wait <= 0;
        else if (!reg_request || reg_ack)
            bk_wait <= 0;
        else
            bk_wait <= bk_wait + 1;
    end

    assign reg_ack   = reg_request && !bk_never && (bk_wait == bk_delay);
    assign reg_err   = bk_err;
    assign reg_rdata = bk_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        int r;
        int cnt;
        r   = -1;
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                r = i;
                cnt++;
            end
        end
        if (cnt != 1) r = -1;
        return r;
    endfunction

    typedef struct {
        int           idx;
        logic         wr;
        logic [15:0]  addr;
        logic [1:0]   size;
        logic [15:0]  wdata;
        logic [15:0]  bk_rd;
        logic         bk_e;
        int           dly;
        logic [N-1:0] e_ack;
        logic [15:0]  e_rd;
        logic         e_err;
    } vec_t;

    vec_t vt[5];
    int   exp_ord[8];

    task automatic run_cont(input string tag, input logic [N-1:0] mask,
                            input int total);
        int n;
        n = 0;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                req_request[i] = 1'b1;
                req_write[i]   = 1'b0;
                req_addr[i]    = 16'h0100 + 16'(i);
            end
        end
        for (int c = 0; c < 100 && n < total; c++) begin
            @(negedge clk);
            if (req_ack != '0) begin
                check($sformatf("%s_grant%0d", tag, n), oh2i(req_ack),
                      exp_ord[n]);
                check($sformatf("%s_cycle%0d", tag, n), c, 2 + 3 * n);
                n++;
            end
            @(posedge clk);
            #1;
        end
        check($sformatf("%s_count", tag), n, total);
        req_request = '0;
    endtask

    int           lat;
    int           iss;
    logic         stab;
    logic [N-1:0] a_ack;
    logic         a_err;
    logic [15:0]  a_rd;
    logic         seen;

    initial begin
        vt[0] = '{0, 1'b0, 16'h0200, 2'd2, 16'h0000, 16'hBEEF, 1'b0, 0,
                  3'b001, 16'hBEEF, 1'b0};
        vt[1] = '{1, 1'b1, 16'h0201, 2'd1, 16'h1234, 16'h0000, 1'b0, 5,
                  3'b010, 16'h0000, 1'b0};
        vt[2] = '{1, 1'b0, 16'h03FF, 2'd2, 16'h0000, 16'hDEAD, 1'b1, 0,
                  3'b010, 16'hDEAD, 1'b1};
        vt[3] = '{2, 1'b0, 16'h0010, 2'd0, 16'h0000, 16'h5A5A, 1'b0, 2,
                  3'b100, 16'h5A5A, 1'b0};
        vt[4] = '{0, 1'b1, 16'hFFFF, 2'd3, 16'hFFFF, 16'h0001, 1'b0, 1,
                  3'b001, 16'h0001, 1'b0};

        rst_n       = 1'b0;
        req_request = '0;
        req_write   = '0;
        req_addr    = '0;
        req_size    = '0;
        req_wdata   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_reg_request", reg_request, 0);
        check("rst_req_ack", req_ack, 0);
        check("rst_req_err", req_err, 0);
        check("rst_req_rdata", req_rdata, 0);
        check("rst_reg_write", reg_write, 0);
        check("rst_reg_addr", reg_addr, 0);
        check("rst_reg_size", reg_size, 0);
        check("rst_reg_wdata", reg_wdata, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            bk_rdata = vt[v].bk_rd;
            bk_err   = vt[v].bk_e;
            bk_delay = vt[v].dly;
            req_request[vt[v].idx] = 1'b1;
            req_write[vt[v].idx]   = vt[v].wr;
            req_addr[vt[v].idx]    = vt[v].addr;
            req_size[vt[v].idx]    = vt[v].size;
            req_wdata[vt[v].idx]   = vt[v].wdata;
            lat   = -1;
            iss   = 0;
            stab  = 1'b1;
            a_ack = '0;
            a_err = 1'b0;
            a_rd  = '0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (reg_request) begin
                    iss++;
                    if ({reg_write, reg_addr, reg_size, reg_wdata} !==
                        {vt[v].wr, vt[v].addr, vt[v].size, vt[v].wdata})
                        stab = 1'b0;
                end
                if (req_ack != '0) begin
                    lat   = c;
                    a_ack = req_ack;
                    a_err = req_err;
                    a_rd  = req_rdata;
                    @(posedge clk);
                    #1;
                    break;
                end
                @(posedge clk);
                #1;
            end
            req_request[vt[v].idx] = 1'b0;
            check($sformatf("v%0d_latency", v), lat, vt[v].dly + 2);
            check($sformatf("v%0d_issue_cycles", v), iss, vt[v].dly + 1);
            check($sformatf("v%0d_cmd_stable", v), stab, 1);
            check($sformatf("v%0d_req_ack", v), a_ack, vt[v].e_ack);
            check($sformatf("v%0d_req_err", v), a_err, vt[v].e_err);
            check($sformatf("v%0d_req_rdata", v), a_rd, vt[v].e_rd);
        end

        // reset while an access is stuck in ISSUE
        bk_delay       = 10;
        bk_err         = 1'b0;
        req_request[2] = 1'b1;
        req_write[2]   = 1'b1;
        req_addr[2]    = 16'h0ABC;
        req_size[2]    = 2'd1;
        req_wdata[2]   = 16'h7777;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (reg_request) break;
        end
        check("midrst_pre_request", reg_request, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_reg_request", reg_request, 0);
        check("midrst_req_ack", req_ack, 0);
        check("midrst_reg_addr", reg_addr, 0);
        check("midrst_reg_write", reg_write, 0);
        check("midrst_reg_wdata", reg_wdata, 0);
        check("midrst_reg_size", reg_size, 0);
        check("midrst_req_err", req_err, 0);
        check("midrst_req_rdata", req_rdata, 0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (req_ack != '0) seen = 1'b1;
        end
        check("midrst_no_ack", seen, 0);
        req_request = '0;
        bk_delay    = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // two requesters after reset: pointer restarts at 0
        exp_ord = '{0, 1, 0, 1, 0, 1, 0, 1};
        run_cont("c01", 3'b011, 8);

        // three requesters: last winner was 1, so 2 goes first
        exp_ord = '{2, 0, 1, 2, 0, 1, 0, 0};
        run_cont("c012", 3'b111, 6);

`ifdef OSD_REG_ARB_TIMEOUT_EN
        bk_never       = 1'b1;
        bk_rdata       = 16'hCAFE;
        bk_err         = 1'b0;
        req_request[0] = 1'b1;
        req_write[0]   = 1'b0;
        req_addr[0]    = 16'h0F00;
        lat   = -1;
        iss   = 0;
        a_ack = '0;
        a_err = 1'b0;
        a_rd  = 16'hFFFF;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (reg_request) iss++;
            if (req_ack != '0) begin
                lat   = c;
                a_ack = req_ack;
                a_err = req_err;
                a_rd  = req_rdata;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        req_request[0] = 1'b0;
        bk_never       = 1'b0;
        check("wdog_issue_cycles", iss, 4);
        check("wdog_latency", lat, 5);
        check("wdog_req_ack", a_ack, 3'b001);
        check("wdog_req_err", a_err, 1);
        check("wdog_req_rdata", a_rd, 0);
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
